// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: clock-enable divider, h/v counters, sync/bright
// decode, and line/frame strobes with a wrapping frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        line_end,
    output logic        frame_end,
    output logic [15:0] frame_count
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);

    // Window test done in 11 bits so an upper bound of 1024 does not wrap.
    function automatic logic in_range(input logic [9:0] c, input int lo, input int hi);
        return ({1'b0, c} >= 11'(lo)) && ({1'b0, c} < 11'(hi));
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             bright_q, bright_d;
    logic             pix_en_s;
    logic             line_end_s;
    logic             frame_end_s;

    // Pixel strobe and line/frame strobes decoded from registered state.
    always_comb begin
        // Masked during reset so a CLK_DIV of 1 still shows pix_en low while held.
        pix_en_s    = (div_q == DIV_LAST) & ~reset;
        line_end_s  = pix_en_s & (hcount_q == H_LAST);
        frame_end_s = line_end_s & (vcount_q == V_LAST);
    end

    // Next-state for divider, counters and the count-aligned decodes.
    always_comb begin
        div_d         = div_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_count_d = frame_count_q;

        if (div_q == DIV_LAST) begin
            div_d = DIV_W'(0);
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (pix_en_s) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                if (vcount_q == V_LAST) begin
                    vcount_d = 10'd0;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
                vcount_d = vcount_q;
            end
        end else begin
            hcount_d = hcount_q;
            vcount_d = vcount_q;
        end

        if (frame_end_s) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end

        // Decoding the next counts keeps sync/bright registered yet in step with the counts.
        hsync_d  = ~in_range(hcount_d, 0, H_SYNC);
        vsync_d  = ~in_range(vcount_d, 0, V_SYNC);
        bright_d = in_range(hcount_d, H_SYNC + H_BP, H_SYNC + H_BP + H_ACTIVE) &
                   in_range(vcount_d, V_SYNC + V_BP, V_SYNC + V_BP + V_ACTIVE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= DIV_W'(0);
            hcount_q      <= 10'd0;
            vcount_q      <= 10'd0;
            frame_count_q <= 16'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            bright_q      <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            bright_q      <= bright_d;
        end
    end

    assign pix_en      = pix_en_s;
    assign line_end    = line_end_s;
    assign frame_end   = frame_end_s;
    assign hCount      = hcount_q;
    assign vCount      = vcount_q;
    assign frame_count = frame_count_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign bright      = bright_q;

endmodule
